// File: rtl/oets_sort_engine.sv
// ============================================================================
// Module   : oets_sort_engine
// Brief    : Iterative odd-even transposition sorter. Loads DATA_CNT words,
//            sorts them in place with one bank of compare-exchange cells and
//            returns the result over a valid/ready handshake.
// Options  : define OETS_EARLY_EXIT_EN to stop once two consecutive phases
//            perform no swap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module oets_sort_engine #(
  parameter int DATA_WIDTH = 64,
  parameter int KEY_WIDTH  = 64,
  parameter int DATA_CNT   = 16,
  parameter int CW         = $clog2(DATA_CNT + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_dir,
  input  logic [DATA_CNT*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_CNT*DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]                  out_phases
);

  localparam int NPAIR = DATA_CNT / 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SORT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_PHASE = CW'(DATA_CNT - 1);
  localparam logic [CW-1:0] PHASE_ONE  = CW'(1);

  logic [1:0]            state_q, state_d;
  logic                  dir_q, dir_d;
  logic [CW-1:0]         phase_q, phase_d;
  logic [DATA_WIDTH-1:0] word_q  [DATA_CNT];
  logic [DATA_WIDTH-1:0] word_d  [DATA_CNT];
  logic [DATA_WIDTH-1:0] word_ph [DATA_CNT];
  logic [NPAIR-1:0]      swap_w;
  logic                  odd_phase;

`ifdef OETS_EARLY_EXIT_EN
  logic swap_seen_q, swap_seen_d;
`endif

  assign odd_phase = phase_q[0];

  // One comparator per pair; odd phases reuse it on the shifted pairing.
  generate
    for (genvar i = 0; i < NPAIR; i++) begin : g_cmp
      logic [KEY_WIDTH-1:0] key_lo;
      logic [KEY_WIDTH-1:0] key_hi;
      logic                 pair_en;
      if (i < NPAIR - 1) begin : g_shared
        assign key_lo  = odd_phase ? word_q[2*i+1][KEY_WIDTH-1:0] : word_q[2*i][KEY_WIDTH-1:0];
        assign key_hi  = odd_phase ? word_q[2*i+2][KEY_WIDTH-1:0] : word_q[2*i+1][KEY_WIDTH-1:0];
        assign pair_en = 1'b1;
      end else begin : g_last
        assign key_lo  = word_q[2*i][KEY_WIDTH-1:0];
        assign key_hi  = word_q[2*i+1][KEY_WIDTH-1:0];
        assign pair_en = ~odd_phase;
      end
      assign swap_w[i] = pair_en & (dir_q ? (key_lo < key_hi) : (key_lo > key_hi));
    end
  endgenerate

  // Word j takes its partner's value when its pair swaps in this phase.
  generate
    for (genvar j = 0; j < DATA_CNT; j++) begin : g_word
      if (j == 0) begin : g_first
        assign word_ph[j] = (!odd_phase && swap_w[0]) ? word_q[1] : word_q[0];
      end else if ((j % 2) == 0) begin : g_even
        assign word_ph[j] = odd_phase ?
                            (swap_w[j/2-1] ? word_q[j-1] : word_q[j]) :
                            (swap_w[j/2]   ? word_q[j+1] : word_q[j]);
      end else if (j == DATA_CNT - 1) begin : g_final
        assign word_ph[j] = (!odd_phase && swap_w[j/2]) ? word_q[j-1] : word_q[j];
      end else begin : g_odd
        assign word_ph[j] = swap_w[j/2] ? (odd_phase ? word_q[j+1] : word_q[j-1]) : word_q[j];
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    word_d  = word_q;
`ifdef OETS_EARLY_EXIT_EN
    swap_seen_d = swap_seen_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < DATA_CNT; k++) begin
            word_d[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
          end
          dir_d   = in_dir;
          phase_d = '0;
          state_d = S_SORT;
        end
      end
      S_SORT: begin
        word_d  = word_ph;
        phase_d = phase_q + PHASE_ONE;
        if (phase_q == LAST_PHASE) begin
          state_d = S_DONE;
        end
`ifdef OETS_EARLY_EXIT_EN
        swap_seen_d = |swap_w;
        if ((phase_q != '0) && !swap_seen_q && !(|swap_w)) begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      phase_q <= '0;
      for (int k = 0; k < DATA_CNT; k++) begin
        word_q[k] <= '0;
      end
`ifdef OETS_EARLY_EXIT_EN
      swap_seen_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      word_q  <= word_d;
`ifdef OETS_EARLY_EXIT_EN
      swap_seen_q <= swap_seen_d;
`endif
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_phases = phase_q;

  generate
    for (genvar k = 0; k < DATA_CNT; k++) begin : g_pack
      assign out_data[k*DATA_WIDTH +: DATA_WIDTH] = word_q[k];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_oets_sort_engine.sv
// ============================================================================
// Module   : tb_oets_sort_engine
// Brief    : Directed self-checking bench for oets_sort_engine (4 words).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oets_sort_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_dir, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_phases;

  logic        s_in_valid, s_in_dir, s_out_ready;
  logic [63:0] s_in_data;
  logic        s_in_ready, s_out_valid;
  logic [63:0] s_out_data;
  logic [2:0]  s_out_phases;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oets_sort_engine #(.DATA_WIDTH(8), .KEY_WIDTH(8), .DATA_CNT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_phases(out_phases)
  );

  oets_sort_engine #(.DATA_WIDTH(16), .KEY_WIDTH(8), .DATA_CNT(4)) u_dut_stab (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_dir(s_in_dir), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_phases(s_out_phases)
  );

  function automatic logic [31:0] p4(input logic [7:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns after the accept edge.
  task automatic start_job(input logic [31:0] d, input logic dir);
    in_data  = d;
    in_dir   = dir;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    int cyc;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_cmp++; if (out_phases !== 3'd0) begin n_err++; $display("FAIL rst_out_phases got %0d want 0", out_phases); end
    tick();
    rst_n = 1'b1;
    tick();
    start_job(p4(9, 3, 7, 1), 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL midrst_out_data got %h want 0", out_data); end
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    start_job(p4(4, 1, 3, 2), 1'b0);
    wait_out(cyc);
    n_cmp++; if (out_data !== p4(1, 2, 3, 4)) begin n_err++; $display("FAIL postrst_data got %h want %h", out_data, p4(1, 2, 3, 4)); end
    tick();
  endtask

  task automatic test_ascending;
    int cyc;
    out_ready = 1'b1;
    start_job(p4(9, 3, 7, 1), 1'b0);
    wait_out(cyc);
    n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL asc_latency got %0d want 4", cyc); end
    n_cmp++; if (out_data !== p4(1, 3, 7, 9)) begin n_err++; $display("FAIL asc_data got %h want %h", out_data, p4(1, 3, 7, 9)); end
    n_cmp++; if (out_phases !== 3'd4) begin n_err++; $display("FAIL asc_phases got %0d want 4", out_phases); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL asc_valid_drop got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL asc_ready_back got %b want 1", in_ready); end
  endtask

  task automatic test_desc_backpressure;
    int cyc;
    out_ready = 1'b0;
    start_job(p4(2, 8, 5, 8), 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL desc_sort_in_ready got %b want 0", in_ready); end
      tick();
      cyc++;
    end
    n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL desc_latency got %0d want 4", cyc); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL desc_hold_valid cyc %0d got %b want 1", k, out_valid); end
      n_cmp++; if (out_data !== p4(8, 8, 5, 2)) begin n_err++; $display("FAIL desc_hold_data cyc %0d got %h want %h", k, out_data, p4(8, 8, 5, 2)); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL desc_hold_in_ready cyc %0d got %b want 0", k, in_ready); end
      if (k < 4) tick();
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL desc_release_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL desc_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_stability;
    int cyc;
    s_out_ready = 1'b1;
    s_in_dir    = 1'b0;
    s_in_data   = {16'h0403, 16'h0305, 16'h0203, 16'h0105};
    s_in_valid  = 1'b1;
    tick();
    s_in_valid = 1'b0;
    cyc = 0;
    while (!s_out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL stab_latency got %0d want 4", cyc); end
    n_cmp++;
    if (s_out_data !== {16'h0305, 16'h0105, 16'h0403, 16'h0203}) begin
      n_err++;
      $display("FAIL stab_data got %h want %h", s_out_data, {16'h0305, 16'h0105, 16'h0403, 16'h0203});
    end
    tick();
  endtask

  task automatic test_early_exit;
    int cyc;
    int exp_cyc;
`ifdef OETS_EARLY_EXIT_EN
    exp_cyc = 2;
`else
    exp_cyc = 4;
`endif
    out_ready = 1'b1;
    start_job(p4(1, 2, 3, 4), 1'b0);
    wait_out(cyc);
    n_cmp++; if (cyc !== exp_cyc) begin n_err++; $display("FAIL sorted_latency got %0d want %0d", cyc, exp_cyc); end
    n_cmp++; if (out_phases !== 3'(exp_cyc)) begin n_err++; $display("FAIL sorted_phases got %0d want %0d", out_phases, exp_cyc); end
    n_cmp++; if (out_data !== p4(1, 2, 3, 4)) begin n_err++; $display("FAIL sorted_data got %h want %h", out_data, p4(1, 2, 3, 4)); end
    tick();
    start_job(p4(4, 3, 2, 1), 1'b0);
    wait_out(cyc);
    n_cmp++; if (out_phases !== 3'd4) begin n_err++; $display("FAIL reversed_phases got %0d want 4", out_phases); end
    n_cmp++; if (out_data !== p4(1, 2, 3, 4)) begin n_err++; $display("FAIL reversed_data got %h want %h", out_data, p4(1, 2, 3, 4)); end
    tick();
  endtask

  task automatic test_back_to_back;
    int cyc;
    out_ready = 1'b0;
    in_data   = p4(5, 6, 1, 0);
    in_dir    = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_data = p4(3, 3, 9, 2);
    in_dir  = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy_in_ready got %b want 0", in_ready); end
      tick();
      cyc++;
    end
    n_cmp++; if (out_data !== p4(0, 1, 5, 6)) begin n_err++; $display("FAIL b2b_job1_data got %h want %h", out_data, p4(0, 1, 5, 6)); end
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_done_in_ready got %b want 0", in_ready); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_out_valid got %b want 0", out_valid); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_job2_accept got %b want 0", in_ready); end
    wait_out(cyc);
    n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL b2b_job2_latency got %0d want 4", cyc); end
    n_cmp++; if (out_data !== p4(9, 3, 3, 2)) begin n_err++; $display("FAIL b2b_job2_data got %h want %h", out_data, p4(9, 3, 3, 2)); end
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_dir      = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    s_in_valid  = 1'b0;
    s_in_dir    = 1'b0;
    s_in_data   = '0;
    s_out_ready = 1'b0;
    #1;
    test_reset();
    test_ascending();
    test_desc_backpressure();
    test_stability();
    test_early_exit();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
